// File: rtl/streamxbar_pkg.sv
// Shared types and helpers for the stream crossbar blocks.
//   demux_state_e : demux packet-routing FSM states
//   dest_width()  : width of a destination index for n outputs (minimum 1 bit)
//   PKT_CNT_WIDTH : width of the optional per-output packet and drop counters
package streamxbar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StDrop
  } demux_state_e;

  localparam int unsigned PKT_CNT_WIDTH = 16;

  function automatic int unsigned dest_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready register slice. The owner decides when to load and
// supplies the downstream ready; the slice holds its payload until drained or
// overwritten.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture data_i this cycle (may coincide with a drain)
//   data_i        : payload to capture
//   ready_i       : downstream ready for the held entry
//   valid_o       : entry held
//   data_o        : held payload (zero after reset)
//   ready_o       : slice can accept a new entry this cycle
module stream_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             ready_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ready_o = !valid_q || ready_i;

endmodule

// File: rtl/stream_demux.sv
// Packet-locked stream demultiplexer: routes one valid/ready input stream to one
// of NUM_OUTPUT outputs. The destination is sampled on the first beat of a
// packet and held until its last beat. Packets addressed past the last output
// are swallowed and flagged with a one-cycle drop_o pulse. One registered stage,
// one-cycle latency, full throughput.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   s_data_i/s_dest_i/s_last_i/s_valid_i/s_ready_o : input stream
//   m_data_o/m_last_o      : payload and last, shared by all outputs
//   m_valid_o/m_ready_i    : per-output handshake (valid is one-hot or zero)
//   drop_o                 : pulse after an invalid-destination packet is fully dropped
//   pkt_cnt_o, drop_cnt_o  : only with STREAM_DEMUX_PKT_CNT_EN defined; per-output
//                            completed-packet counters (wrapping) and a
//                            saturating drop counter
module stream_demux
  import streamxbar_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = dest_width(NUM_OUTPUT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [DEST_WIDTH-1:0] s_dest_i,
  input  logic                  s_last_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [NUM_OUTPUT-1:0] m_valid_o,
  input  logic [NUM_OUTPUT-1:0] m_ready_i,
`ifdef STREAM_DEMUX_PKT_CNT_EN
  output logic [NUM_OUTPUT-1:0][PKT_CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [PKT_CNT_WIDTH-1:0]                 drop_cnt_o,
`endif
  output logic                  drop_o
);

  localparam int unsigned RegWidth = DEST_WIDTH + 1 + DATA_WIDTH;
  // One extra bit so the compare stays meaningful when NUM_OUTPUT == 2**DEST_WIDTH.
  localparam logic [DEST_WIDTH:0] NumOut = NUM_OUTPUT[DEST_WIDTH:0];

  demux_state_e state_q, state_d;

  logic                  s_xfer;
  logic                  dest_ok;
  logic                  load;
  logic                  drop_d, drop_q;
  logic [DEST_WIDTH-1:0] load_sel;
  logic [DEST_WIDTH-1:0] sel;
  logic [NUM_OUTPUT-1:0] sel_onehot;
  logic                  sel_ready;
  logic                  reg_valid;
  logic                  reg_ready;
  logic [RegWidth-1:0]   reg_data;

  assign dest_ok = {1'b0, s_dest_i} < NumOut;
  assign s_xfer  = s_valid_i && s_ready_o;

  always_comb begin
    sel_onehot = '0;
    for (int unsigned k = 0; k < NUM_OUTPUT; k++) begin
      sel_onehot[k] = (sel == DEST_WIDTH'(k));
    end
  end

  // Only the selected output's ready matters.
  assign sel_ready = |(m_ready_i & sel_onehot);
  assign m_valid_o = reg_valid ? sel_onehot : '0;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (s_xfer && !s_last_i) state_d = dest_ok ? StRoute : StDrop;
      end
      StRoute, StDrop: begin
        if (s_xfer && s_last_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / control logic.
  always_comb begin
    s_ready_o = reg_ready;
    load      = 1'b0;
    drop_d    = 1'b0;
    load_sel  = sel;
    unique case (state_q)
      StIdle: begin
        load_sel = s_dest_i;
        load     = s_xfer && dest_ok;
        drop_d   = s_xfer && !dest_ok && s_last_i;
      end
      StRoute: begin
        load = s_xfer;
      end
      StDrop: begin
        s_ready_o = 1'b1;
        drop_d    = s_xfer && s_last_i;
      end
      default: ;
    endcase
  end

  stream_reg #(
    .Width(RegWidth)
  ) u_out_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .data_i ({load_sel, s_last_i, s_data_i}),
    .ready_i(sel_ready),
    .valid_o(reg_valid),
    .data_o (reg_data),
    .ready_o(reg_ready)
  );

  assign {sel, m_last_o, m_data_o} = reg_data;
  assign drop_o = drop_q;

`ifdef STREAM_DEMUX_PKT_CNT_EN
  logic [NUM_OUTPUT-1:0][PKT_CNT_WIDTH-1:0] pkt_cnt_q;
  logic [PKT_CNT_WIDTH-1:0]                 drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUTPUT; k++) begin
        if (m_valid_o[k] && m_ready_i[k] && m_last_o) begin
          pkt_cnt_q[k] <= pkt_cnt_q[k] + PKT_CNT_WIDTH'(1);
        end
      end
      if (drop_q && (drop_cnt_q != {PKT_CNT_WIDTH{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + PKT_CNT_WIDTH'(1);
      end
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux with 5 outputs (dest 5..7 are invalid). A queue-based
// packet model predicts, every cycle, which beat must be on the outputs, the
// input ready, drop pulses and (optionally) the counters.
module tb_stream_demux;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int TW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [TW-1:0] s_dest = '0;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic [N-1:0]  m_valid_o;
  logic [N-1:0]  m_ready = '1;
  logic          drop_o;
`ifdef STREAM_DEMUX_PKT_CNT_EN
  logic [N-1:0][15:0] pkt_cnt_o;
  logic [15:0]        drop_cnt_o;
`endif

  stream_demux #(
    .NUM_OUTPUT(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_data_i (s_data),
    .s_dest_i (s_dest),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready),
`ifdef STREAM_DEMUX_PKT_CNT_EN
    .pkt_cnt_o (pkt_cnt_o),
    .drop_cnt_o(drop_cnt_o),
`endif
    .drop_o   (drop_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          dest;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t q[$];          // beats accepted but not yet delivered, in order
  bit    in_pkt;        // inside a packet (first beat seen, last not yet)
  bit    dropping;      // current packet has an invalid destination
  int    lock_dest;
  bit    exp_drop;
  int    drop_cnt;
  int    pkt_cnt[N];
  bit    exp_rdy;
  logic [N-1:0] ev;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      q.delete();
      in_pkt = 0; dropping = 0; lock_dest = 0; exp_drop = 0; drop_cnt = 0;
      for (int k = 0; k < N; k++) pkt_cnt[k] = 0;
    end else begin
      ev = '0;
      if (q.size() != 0) ev[q[0].dest] = 1'b1;
      chk("m_valid", 64'(m_valid_o), 64'(ev));
      if (q.size() != 0) begin
        chk("m_data", 64'(m_data_o), 64'(q[0].data));
        chk("m_last", 64'(m_last_o), 64'(q[0].last));
      end
      chk("drop_o", 64'(drop_o), 64'(exp_drop));
      exp_rdy = dropping ? 1'b1 : ((q.size() == 0) || m_ready[q[0].dest]);
      chk("s_ready", 64'(s_ready_o), 64'(exp_rdy));
`ifdef STREAM_DEMUX_PKT_CNT_EN
      for (int k = 0; k < N; k++) chk($sformatf("pkt_cnt[%0d]", k), 64'(pkt_cnt_o[k]), 64'(pkt_cnt[k]));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(drop_cnt));
`endif
      // advance the model across the coming clock edge
      if (q.size() != 0 && m_ready[q[0].dest]) begin
        if (q[0].last) pkt_cnt[q[0].dest] = (pkt_cnt[q[0].dest] + 1) % 65536;
        void'(q.pop_front());
      end
      if (exp_drop && drop_cnt < 65535) drop_cnt++;
      exp_drop = 0;
      if (s_valid && exp_rdy) begin
        if (!in_pkt) begin
          in_pkt    = 1;
          lock_dest = int'(s_dest);
          dropping  = lock_dest >= N;
        end
        if (!dropping) q.push_back('{dest: lock_dest, data: s_data, last: s_last});
        if (s_last) begin
          exp_drop = dropping;
          in_pkt   = 0;
          dropping = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rdy_mode = 0;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rdy_mode) m_ready = N'($urandom);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Present one beat and hold it until it has been accepted.
  task automatic send(input logic [TW-1:0] d, input logic [31:0] data, input bit last);
    bit acc = 0;
    s_valid = 1'b1; s_dest = d; s_data = data; s_last = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_i);
      acc = s_ready_o;
      cyc();
    end
    chk("send_accept", 64'(acc), 64'd1);
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (2) cyc();
    chk("rst_m_valid", 64'(m_valid_o), 64'd0);
    chk("rst_m_data", 64'(m_data_o), 64'd0);
    chk("rst_m_last", 64'(m_last_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
    chk("rst_s_ready", 64'(s_ready_o), 64'd1);
    rst_ni = 1'b1;
    cyc();

    // 1: single-beat packet to dest 2
    send(3'd2, 32'hA5, 1'b1);
    chk("t1_valid", 64'(m_valid_o), 64'b00100);
    chk("t1_data", 64'(m_data_o), 64'hA5);
    chk("t1_last", 64'(m_last_o), 64'd1);
    cyc();
    chk("t1_idle", 64'(m_valid_o), 64'd0);

    // 2: three-beat packet, dest locked to 1
    send(3'd1, 32'h100, 1'b0);
    chk("t2_b0", 64'(m_valid_o), 64'b00010);
    send(3'd3, 32'h101, 1'b0);
    chk("t2_b1", 64'(m_valid_o), 64'b00010);
    chk("t2_b1_data", 64'(m_data_o), 64'h101);
    send(3'd3, 32'h102, 1'b1);
    chk("t2_b2", 64'(m_valid_o), 64'b00010);
    chk("t2_b2_last", 64'(m_last_o), 64'd1);
    cyc();

    // 4: back-to-back packets to dest 3 then dest 0
    send(3'd3, 32'h300, 1'b1);
    chk("t4_first", 64'(m_valid_o), 64'b01000);
    chk("t4_ready", 64'(s_ready_o), 64'd1);
    send(3'd0, 32'h301, 1'b1);
    chk("t4_second", 64'(m_valid_o), 64'b00001);
    chk("t4_data", 64'(m_data_o), 64'h301);
    cyc();

    // 3: backpressure on output 0
    m_ready = 5'b11110;
    send(3'd0, 32'hE0, 1'b0);
    s_valid = 1'b1; s_data = 32'hE1; s_last = 1'b1; s_dest = 3'd4;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_ready", 64'(s_ready_o), 64'd0);
      chk("t3_stall_data", 64'(m_data_o), 64'hE0);
      chk("t3_stall_valid", 64'(m_valid_o), 64'b00001);
      cyc();
    end
    m_ready = '1;
    cyc();
    s_valid = 1'b0;
    chk("t3_resume_data", 64'(m_data_o), 64'hE1);
    chk("t3_resume_last", 64'(m_last_o), 64'd1);
    cyc();
    chk("t3_empty", 64'(m_valid_o), 64'd0);

    // 5: two-beat packet to invalid dest 6
    send(3'd6, 32'hF0, 1'b0);
    chk("t5_valid", 64'(m_valid_o), 64'd0);
    chk("t5_ready", 64'(s_ready_o), 64'd1);
    send(3'd2, 32'hF1, 1'b1);
    chk("t5_drop", 64'(drop_o), 64'd1);
    chk("t5_valid2", 64'(m_valid_o), 64'd0);
    cyc();
    chk("t5_drop_end", 64'(drop_o), 64'd0);
`ifdef STREAM_DEMUX_PKT_CNT_EN
    chk("t5_drop_cnt", 64'(drop_cnt_o), 64'd1);
`endif

    // 6: reset in the middle of a packet
    send(3'd2, 32'h600, 1'b0);
    chk("t6_pre", 64'(m_valid_o), 64'b00100);
    rst_ni = 1'b0;
    #1;
    chk("t6_reset", 64'(m_valid_o), 64'd0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    send(3'd1, 32'h601, 1'b1);
    chk("t6_new", 64'(m_valid_o), 64'b00010);
    chk("t6_data", 64'(m_data_o), 64'h601);
    cyc();

    // random traffic with random sink backpressure
    rdy_mode = 1;
    for (int p = 0; p < 250; p++) begin
      int len;
      logic [TW-1:0] d;
      len = $urandom_range(1, 4);
      d   = TW'($urandom_range(0, 7));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) cyc();
        send((b == 0) ? d : TW'($urandom_range(0, 7)), $urandom, b == len - 1);
      end
    end
    rdy_mode = 0;
    cyc();
    m_ready = '1;
    repeat (5) cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(m_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Routes one valid/ready input stream to one of NUM_OUTPUT output streams, selected by a destination field. It is the split side of the crossbar, the counterpart to the fixed-priority merge arbiter. Routing is packet-locked: the destination is sampled on the first beat and held until the beat with last set. A single registered output stage gives 1-cycle latency at full throughput.

Parameters:
NUM_OUTPUT, 4, number of output streams (>=2)
DATA_WIDTH, 32, payload width in bits
DEST_WIDTH, $clog2(NUM_OUTPUT), width of the destination field

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_data_i  in  DATA_WIDTH  input payload
s_dest_i  in  DEST_WIDTH  destination index; sampled on the first beat of a packet only
s_last_i  in  1  last beat of packet
s_valid_i  in  1  input valid
s_ready_o  out  1  input ready
m_data_o  out  DATA_WIDTH  payload, shared by all outputs
m_last_o  out  1  last beat, shared by all outputs
m_valid_o  out  NUM_OUTPUT  per-output valid, one-hot or zero
m_ready_i  in  NUM_OUTPUT  per-output ready
drop_o  out  1  one-cycle pulse when a packet with an invalid dest completes its drop

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0; m_valid_o=0; m_data_o=0; m_last_o=0; sel=0; drop_o=0.
- Input transfer: s_valid_i && s_ready_o. Output transfer on channel k: m_valid_o[k] && m_ready_i[k].
- Output register: holds out_valid, data, last and sel. m_valid_o = out_valid ? (1<<sel) : 0.
- s_ready_o = !out_valid || m_ready_i[sel] in IDLE and ROUTE. It is 1 in DROP. It is purely combinational from the register state and m_ready_i; it never depends on s_valid_i.
- Latency: an accepted beat appears on its output the next cycle. With the sink ready every cycle, throughput is one beat per cycle.
- m_ready_i of unselected outputs is ignored.
- FSM states: IDLE, ROUTE, DROP.
  - IDLE, transfer with s_dest_i < NUM_OUTPUT: load the register and latch sel=s_dest_i. Go to ROUTE if !s_last_i, otherwise stay in IDLE (single-beat packet).
  - IDLE, transfer with s_dest_i >= NUM_OUTPUT (possible only if NUM_OUTPUT is not a power of 2): discard the beat and leave the register unchanged. If s_last_i, pulse drop_o next cycle and stay in IDLE; otherwise go to DROP.
  - ROUTE: each transfer loads the register with the locked sel, ignoring s_dest_i. The transfer with s_last_i returns to IDLE.
  - DROP: all beats are accepted and discarded. The transfer with s_last_i pulses drop_o next cycle and returns to IDLE.
- Back-to-back packets: a last beat and the next packet's first beat may transfer on consecutive cycles, even to a different output. The new sel applies only to the newly loaded beat; the register never holds two beats.
- Simultaneous output-drain and input-load in the same cycle is permitted; the register is overwritten with the new beat.
- Stability: while out_valid && !m_ready_i[sel], the register is unchanged.
- Reset mid-packet: a partial packet is lost and the FSM returns to IDLE; there is no recovery beat.

Optional Feature:
- Macro: STREAM_DEMUX_PKT_CNT_EN.
- Defined: adds output pkt_cnt_o [NUM_OUTPUT][15:0].
  - Entry k increments on each output transfer on channel k with m_last_o=1.
  - Wraps 0xFFFF->0. Resets to 0.
- Also adds output drop_cnt_o [15:0], which increments on each drop_o pulse and saturates at 0xFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package streamxbar_pkg holds:
  - the state enum typedef (IDLE, ROUTE, DROP);
  - the function dest_width(n) = (n>1) ? $clog2(n) : 1;
  - the counter width constant PKT_CNT_WIDTH=16.
- Sub-module stream_reg: a one-entry valid/ready register slice, parameterised on payload width. Here the payload is {sel, last, data}. The demux FSM drives its load enable and ready mux.

Test Plan:
1. Single-beat packet, dest=2, data=0xA5, last=1, all m_ready_i=1111 -> next cycle m_valid_o=0100, m_data_o=0xA5, m_last_o=1; the cycle after, m_valid_o=0000.
2. 3-beat packet, dest=1 on beat 0, then dest driven 3 on beats 1-2 -> all three beats appear on m_valid_o=0010 in consecutive cycles; the final beat has m_last_o=1.
3. Backpressure: packet to dest=0 with m_ready_i[0]=0 for 3 cycles -> s_ready_o=0 and m_data_o stable for those cycles; after release, beats resume with no loss or duplication.
4. Back-to-back packets to dest 3 then dest 0, sink always ready -> m_valid_o=1000 then 0001 on consecutive cycles; s_ready_o stays 1.
5. NUM_OUTPUT=3, 2-beat packet with dest=3 -> m_valid_o stays 000, s_ready_o=1, drop_o pulses for one cycle after beat 2; with STREAM_DEMUX_PKT_CNT_EN, drop_cnt_o=1.
6. Assert rst_ni mid-packet (after beat 1 of 4, dest=2) -> m_valid_o=0000 immediately; after release, a new packet to dest=1 routes to m_valid_o=0010.
